// File: rtl/cordic_vector_if.sv
`timescale 1ns/1ps
// Purpose : sample/result bundle for the vectoring CORDIC (Cartesian in, magnitude/phase out).
// Latency : n/a (wires only).
// Backpr. : none; 'enable' is a global advance, so the producer holds the whole pipe by dropping it.
// Ports   : enable, i_valid, i_xval, i_yval (producer -> block); o_valid, o_mag, o_phase (block -> consumer).
interface cordic_vector_if #(
   parameter int PW = 12,
   parameter int IW = 31,
   parameter int OW = 32
);
   logic                 enable;
   logic                 i_valid;
   logic signed [IW-1:0] i_xval;
   logic signed [IW-1:0] i_yval;
   logic                 o_valid;
   logic [OW-1:0]        o_mag;
   logic [PW-1:0]        o_phase;

   modport master (
      output enable, i_valid, i_xval, i_yval,
      input  o_valid, o_mag, o_phase
   );

   modport slave (
      input  enable, i_valid, i_xval, i_yval,
      output o_valid, o_mag, o_phase
   );
endinterface

// File: rtl/cordic_vector.sv
`timescale 1ns/1ps
// Purpose : pipelined vectoring-mode CORDIC, (x, y) -> (K*|v|, atan2(y, x) as a binary angle).
// Latency : NSTAGES+2 enabled cycles, one sample per cycle, order preserved.
// Backpr. : none; enable=0 freezes every register (outputs included) and i_valid is ignored.
// Ports   : clk, reset (async, active-high); bus.slave carries enable, i_valid/i_xval/i_yval
//           in and o_valid/o_mag/o_phase out. Parameters must match those of the bus instance;
//           OW >= IW+1, NSTAGES <= PW, PW <= 28.
module cordic_vector #(
   parameter int PW      = 12,
   parameter int IW      = 31,
   parameter int OW      = 32,
   parameter int NSTAGES = 11
) (
   input  logic           clk,
   input  logic           reset,
   cordic_vector_if.slave bus
);
   // Working width: one bit for the negation of the most negative input, one for CORDIC growth.
   localparam int WW = IW + 2;
   // Phase accumulator carries 3 guard bits below the output LSB.
   localparam int AW = PW + 3;
   // The reference angle table below is scaled to 2^32 per full circle.
   localparam int SH = 32 - AW;

   typedef logic signed [WW-1:0] word_t;
   typedef logic [AW-1:0]        acc_t;

   // atan(2^-idx) as a fraction of a full turn, rounded to nearest at AW bits.
   // Beyond idx 15, atan(2^-idx) == 2^-idx to well below one accumulator LSB.
   function automatic acc_t atan_entry(input int idx);
      logic [31:0] raw;
      logic [32:0] sum;
      case (idx)
         0:       raw = 32'h2000_0000;
         1:       raw = 32'h12e4_051d;
         2:       raw = 32'h09fb_385b;
         3:       raw = 32'h0511_11d4;
         4:       raw = 32'h028b_0d43;
         5:       raw = 32'h0145_d7e1;
         6:       raw = 32'h00a2_f61e;
         7:       raw = 32'h0051_7c55;
         8:       raw = 32'h0028_be53;
         9:       raw = 32'h0014_5f2e;
         10:      raw = 32'h000a_2f98;
         11:      raw = 32'h0005_17cc;
         12:      raw = 32'h0002_8be6;
         13:      raw = 32'h0001_45f3;
         14:      raw = 32'h0000_a2f9;
         15:      raw = 32'h0000_517c;
         default: raw = 32'h0000_517c >> (idx - 15);
      endcase
      sum = {1'b0, raw} + (33'd1 << (SH - 1));
      return sum[SH +: AW];
   endfunction

   // Index 0 is the pre-rotation register, index i+1 the output of micro-rotation i.
   word_t            x_q  [0:NSTAGES];
   word_t            y_q  [0:NSTAGES];
   acc_t             ph_q [0:NSTAGES];
   logic [NSTAGES:0] vld_q;
   logic [NSTAGES:0] zf_q;

   word_t            x_d  [0:NSTAGES];
   word_t            y_d  [0:NSTAGES];
   acc_t             ph_d [0:NSTAGES];
   logic [NSTAGES:0] vld_d;
   logic [NSTAGES:0] zf_d;

   word_t x_ext;
   word_t y_ext;

   assign x_ext = {{2{bus.i_xval[IW-1]}}, bus.i_xval};
   assign y_ext = {{2{bus.i_yval[IW-1]}}, bus.i_yval};

   always_comb begin
      // Pre-rotation: fold the left half-plane onto the right by a 180 degree turn,
      // so the micro-rotations only need to cover +/-90 degrees.
      x_d[0]   = x_ext;
      y_d[0]   = y_ext;
      ph_d[0]  = '0;
      if (x_ext[WW-1]) begin
         x_d[0]  = -x_ext;
         y_d[0]  = -y_ext;
         ph_d[0] = acc_t'(1) << (AW - 1);
      end
      // The origin has no defined angle; the flag forces a clean 0/0 result at the end.
      zf_d[0]  = (bus.i_xval == '0) && (bus.i_yval == '0);
      vld_d[0] = bus.i_valid;

      // Each micro-rotation drives y toward zero; both updates use the stage inputs.
      for (int i = 0; i < NSTAGES; i++) begin
         if (!y_q[i][WW-1]) begin
            x_d[i+1]  = x_q[i] + (y_q[i] >>> i);
            y_d[i+1]  = y_q[i] - (x_q[i] >>> i);
            ph_d[i+1] = ph_q[i] + atan_entry(i);
         end else begin
            x_d[i+1]  = x_q[i] - (y_q[i] >>> i);
            y_d[i+1]  = y_q[i] + (x_q[i] >>> i);
            ph_d[i+1] = ph_q[i] - atan_entry(i);
         end
         vld_d[i+1] = vld_q[i];
         zf_d[i+1]  = zf_q[i];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i <= NSTAGES; i++) begin
            x_q[i]  <= '0;
            y_q[i]  <= '0;
            ph_q[i] <= '0;
         end
         vld_q <= '0;
         zf_q  <= '0;
      end else if (bus.enable) begin
         for (int i = 0; i <= NSTAGES; i++) begin
            x_q[i]  <= x_d[i];
            y_q[i]  <= y_d[i];
            ph_q[i] <= ph_d[i];
         end
         vld_q <= vld_d;
         zf_q  <= zf_d;
      end
   end

   // Output register. Magnitude/phase only load on a valid result, so they stay at zero
   // after reset until the first real sample arrives and otherwise hold the last result.
   // The +4 rounds half-up on the guard bits; the carry out of the top wraps 360 to 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.o_valid <= 1'b0;
         bus.o_mag   <= '0;
         bus.o_phase <= '0;
      end else if (bus.enable) begin
         bus.o_valid <= vld_q[NSTAGES];
         if (vld_q[NSTAGES]) begin
            if (zf_q[NSTAGES]) begin
               bus.o_mag   <= '0;
               bus.o_phase <= '0;
            end else begin
               bus.o_mag   <= OW'($unsigned(x_q[NSTAGES]));
               bus.o_phase <= PW'((ph_q[NSTAGES] + acc_t'(4)) >> 3);
            end
         end
      end
   end
endmodule

// File: tb/tb_cordic_vector.sv
`timescale 1ns/1ps
// Bench for cordic_vector: random and directed samples checked against an atan2/sqrt model.
module tb_cordic_vector;
   localparam int     PW      = 12;
   localparam int     IW      = 31;
   localparam int     OW      = 32;
   localparam int     NSTAGES = 11;
   localparam int     LAT     = NSTAGES + 2;
   localparam real    K       = 1.6467602581;
   localparam real    PI      = 3.14159265358979;
   localparam longint P28     = 64'sd268435456;
   localparam longint P30     = 64'sd1073741824;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   n_checks = 0;
   int   n_fail   = 0;

   cordic_vector_if #(.PW(PW), .IW(IW), .OW(OW)) bus ();

   cordic_vector #(.PW(PW), .IW(IW), .OW(OW), .NSTAGES(NSTAGES)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit en, input bit v, input longint x, input longint y);
      bus.enable  = en;
      bus.i_valid = v;
      bus.i_xval  = IW'(x);
      bus.i_yval  = IW'(y);
   endtask

   // Reference model: ideal binary angle and gain-scaled magnitude.
   function automatic int ideal_phase(input longint x, input longint y);
      real p;
      if (x == 0 && y == 0) return 0;
      p = $atan2(real'(y), real'(x)) / (2.0 * PI) * 4096.0;
      if (p < 0.0) p = p + 4096.0;
      return int'($floor(p + 0.5)) % 4096;
   endfunction

   function automatic real ideal_mag(input longint x, input longint y);
      return K * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
   endfunction

   function automatic int phase_dist(input int a, input int b);
      int d;
      d = ((a - b) % 4096 + 4096) % 4096;
      return (d > 2048) ? 4096 - d : d;
   endfunction

   function automatic bit mag_close(input logic [OW-1:0] got, input real want);
      real g;
      g = got;
      if (want == 0.0) return got == '0;
      return (g - want <= 0.001 * want) && (want - g <= 0.001 * want);
   endfunction

   function automatic longint iabs(input longint v);
      return (v < 0) ? -v : v;
   endfunction

   task automatic rand_xy(output longint x, output longint y);
      int sh;
      if ($urandom_range(15, 0) == 0) begin
         x = 0;
         y = 0;
         return;
      end
      sh = ($urandom_range(3, 0) == 0) ? int'($urandom_range(7, 0)) : 0;
      do begin
         x = (longint'($urandom_range(32'h7fff_ffff, 0)) - P30) >>> sh;
         y = (longint'($urandom_range(32'h7fff_ffff, 0)) - P30) >>> sh;
      end while (iabs(x) < 64'sd8388608 && iabs(y) < 64'sd8388608);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 0);
      #1 reset = 1'b1;
      tick();
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, want 0", bus.o_valid); end
      n_checks++;
      if (bus.o_mag !== '0) begin n_fail++; $display("FAIL reset_mag: got %0d, want 0", bus.o_mag); end
      n_checks++;
      if (bus.o_phase !== '0) begin n_fail++; $display("FAIL reset_phase: got 0x%03h, want 0x000", bus.o_phase); end
      #2 reset = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         n_checks++;
         if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid[%0d]: got %b, want 0", c, bus.o_valid); end
      end
   endtask

   task automatic test_single_latency();
      int edges;
      drive(1, 1, P28, 0);
      tick();
      edges = 1;
      drive(1, 0, 0, 0);
      while (bus.o_valid !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      n_checks++;
      if (edges !== LAT) begin n_fail++; $display("FAIL single_latency: got %0d cycles, want %0d", edges, LAT); end
      n_checks++;
      if (bus.o_phase !== 12'h000) begin n_fail++; $display("FAIL single_phase: got 0x%03h, want 0x000", bus.o_phase); end
      n_checks++;
      if (!mag_close(bus.o_mag, ideal_mag(P28, 0))) begin
         n_fail++; $display("FAIL single_mag: got %0d, want %0.0f +/-0.1%%", bus.o_mag, ideal_mag(P28, 0));
      end
      tick();
      n_checks++;
      if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_pulse: got o_valid %b, want 0", bus.o_valid); end
   endtask

   task automatic test_axis_back_to_back();
      longint ax [4];
      longint ay [4];
      int     ap [4];
      ax = '{0, -P28, 0, P28};
      ay = '{P28, 0, -P28, P28};
      ap = '{32'h400, 32'h800, 32'hC00, 32'h200};
      for (int c = 0; c < LAT + 6; c++) begin
         if (c < 4) drive(1, 1, ax[c], ay[c]);
         else       drive(1, 0, 0, 0);
         tick();
         n_checks++;
         if (bus.o_valid !== ((c >= LAT - 1) && (c < LAT + 3))) begin
            n_fail++; $display("FAIL axis_valid[%0d]: got %b, want %b", c, bus.o_valid, (c >= LAT - 1) && (c < LAT + 3));
         end
         if (c >= LAT - 1 && c < LAT + 3) begin
            n_checks++;
            if (phase_dist(int'(bus.o_phase), ap[c-LAT+1]) > 2) begin
               n_fail++; $display("FAIL axis_phase[%0d]: got 0x%03h, want 0x%03h +/-2", c - LAT + 1, bus.o_phase, ap[c-LAT+1]);
            end
         end
         if (c == LAT + 2) begin
            n_checks++;
            if (!mag_close(bus.o_mag, ideal_mag(P28, P28))) begin
               n_fail++; $display("FAIL axis_mag: got %0d, want %0.0f +/-0.1%%", bus.o_mag, ideal_mag(P28, P28));
            end
         end
      end
   endtask

   task automatic test_extremes();
      longint ex [4];
      longint ey [4];
      ex = '{0, -P30, P28, -P30};
      ey = '{0, 0, -1, -P30};
      for (int t = 0; t < 4; t++) begin
         for (int c = 0; c < LAT; c++) begin
            if (c == 0) drive(1, 1, ex[t], ey[t]);
            else        drive(1, 0, 0, 0);
            tick();
         end
         n_checks++;
         if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL extreme_valid[%0d]: got %b, want 1", t, bus.o_valid); end
         case (t)
            0: begin
               n_checks++;
               if (bus.o_mag !== '0 || bus.o_phase !== '0) begin
                  n_fail++; $display("FAIL zero_in: got mag %0d phase 0x%03h, want 0 and 0x000", bus.o_mag, bus.o_phase);
               end
            end
            1: begin
               n_checks++;
               if (phase_dist(int'(bus.o_phase), 32'h800) > 2) begin
                  n_fail++; $display("FAIL neg_full_phase: got 0x%03h, want 0x800", bus.o_phase);
               end
               n_checks++;
               if (!mag_close(bus.o_mag, K * 1073741824.0)) begin
                  n_fail++; $display("FAIL neg_full_mag: got %0d, want %0.0f", bus.o_mag, K * 1073741824.0);
               end
            end
            2: begin
               n_checks++;
               if (bus.o_phase !== 12'hFFF && bus.o_phase !== 12'h000) begin
                  n_fail++; $display("FAIL wrap_360: got 0x%03h, want 0xFFF or 0x000", bus.o_phase);
               end
            end
            default: begin
               n_checks++;
               if (phase_dist(int'(bus.o_phase), 32'hA00) > 2) begin
                  n_fail++; $display("FAIL neg_corner_phase: got 0x%03h, want 0xA00", bus.o_phase);
               end
            end
         endcase
      end
   endtask

   task automatic test_stall();
      longint          sx [8];
      longint          sy [8];
      logic [OW-1:0]   hm;
      logic [PW-1:0]   hp;
      int              k;
      for (int i = 0; i < 8; i++) rand_xy(sx[i], sy[i]);
      hm = bus.o_mag;
      hp = bus.o_phase;
      for (int c = 0; c < 30; c++) begin
         if (c < 4)       drive(1, 1, sx[c], sy[c]);
         else if (c < 9)  drive(0, 1, 64'sd12345, -64'sd999);
         else if (c < 13) drive(1, 1, sx[c-5], sy[c-5]);
         else             drive(1, 0, 0, 0);
         tick();
         n_checks++;
         if (bus.o_valid !== (c >= LAT + 4 && c <= LAT + 11)) begin
            n_fail++; $display("FAIL stall_valid[%0d]: got %b, want %b", c, bus.o_valid, (c >= LAT + 4 && c <= LAT + 11));
         end
         if (c >= 4 && c < 9) begin
            n_checks++;
            if (bus.o_mag !== hm || bus.o_phase !== hp) begin
               n_fail++; $display("FAIL stall_frozen[%0d]: got %0d/0x%03h, want %0d/0x%03h", c, bus.o_mag, bus.o_phase, hm, hp);
            end
         end
         if (c >= LAT + 4 && c <= LAT + 11) begin
            k = c - LAT - 4;
            n_checks++;
            if (phase_dist(int'(bus.o_phase), ideal_phase(sx[k], sy[k])) > 2 ||
                !mag_close(bus.o_mag, ideal_mag(sx[k], sy[k]))) begin
               n_fail++; $display("FAIL stall_result[%0d]: got %0d/0x%03h, want %0.0f/0x%03h", k, bus.o_mag, bus.o_phase,
                                  ideal_mag(sx[k], sy[k]), ideal_phase(sx[k], sy[k]));
            end
         end
      end
   endtask

   task automatic test_random();
      longint        qx [$];
      longint        qy [$];
      int            qdue [$];
      int            en_cnt;
      bit            en, v, exp_v;
      longint        x, y, ox, oy;
      logic          pv;
      logic [OW-1:0] pm;
      logic [PW-1:0] pp;
      en_cnt = 0;
      pv = bus.o_valid;
      pm = bus.o_mag;
      pp = bus.o_phase;
      for (int c = 0; c < 400; c++) begin
         en = (c >= 300) || ($urandom_range(9, 0) < 8);
         v  = (c < 300) && ($urandom_range(9, 0) < 7);
         rand_xy(x, y);
         drive(en, v, x, y);
         tick();
         if (en) begin
            en_cnt++;
            if (v) begin
               qx.push_back(x);
               qy.push_back(y);
               qdue.push_back(en_cnt + LAT - 1);
            end
            exp_v = (qdue.size() > 0) && (qdue[0] == en_cnt);
            n_checks++;
            if (bus.o_valid !== exp_v) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b, want %b", c, bus.o_valid, exp_v); end
            if (exp_v) begin
               ox = qx.pop_front();
               oy = qy.pop_front();
               void'(qdue.pop_front());
               n_checks++;
               if (phase_dist(int'(bus.o_phase), ideal_phase(ox, oy)) > 2) begin
                  n_fail++; $display("FAIL rand_phase[%0d]: got 0x%03h, want 0x%03h +/-2", c, bus.o_phase, ideal_phase(ox, oy));
               end
               n_checks++;
               if (!mag_close(bus.o_mag, ideal_mag(ox, oy))) begin
                  n_fail++; $display("FAIL rand_mag[%0d]: got %0d, want %0.0f +/-0.1%%", c, bus.o_mag, ideal_mag(ox, oy));
               end
            end
         end else begin
            n_checks++;
            if (bus.o_valid !== pv || bus.o_mag !== pm || bus.o_phase !== pp) begin
               n_fail++; $display("FAIL rand_hold[%0d]: got %b/%0d/0x%03h, want %b/%0d/0x%03h", c,
                                  bus.o_valid, bus.o_mag, bus.o_phase, pv, pm, pp);
            end
         end
         pv = bus.o_valid;
         pm = bus.o_mag;
         pp = bus.o_phase;
      end
      n_checks++;
      if (qdue.size() !== 0) begin n_fail++; $display("FAIL rand_drain: got %0d results missing, want 0", qdue.size()); end
   endtask

   task automatic test_reset_mid_stream();
      longint x, y;
      int     edges;
      for (int c = 0; c < LAT; c++) begin
         rand_xy(x, y);
         drive(1, c < 6, x, y);
         tick();
      end
      n_checks++;
      if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL midrst_pre: got o_valid %b, want 1", bus.o_valid); end
      #2 reset = 1'b1;
      #1;
      n_checks++;
      if (bus.o_valid !== 1'b0 || bus.o_mag !== '0 || bus.o_phase !== '0) begin
         n_fail++; $display("FAIL midrst_async: got %b/%0d/0x%03h, want 0/0/0x000", bus.o_valid, bus.o_mag, bus.o_phase);
      end
      drive(1, 0, 0, 0);
      tick();
      #2 reset = 1'b0;
      for (int c = 0; c < 20; c++) begin
         tick();
         n_checks++;
         if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d]: got %b, want 0", c, bus.o_valid); end
      end
      drive(1, 1, -P28, P28);
      tick();
      edges = 1;
      drive(1, 0, 0, 0);
      while (bus.o_valid !== 1'b1 && edges < 40) begin
         tick();
         edges++;
      end
      n_checks++;
      if (edges !== LAT) begin n_fail++; $display("FAIL midrst_latency: got %0d cycles, want %0d", edges, LAT); end
      n_checks++;
      if (phase_dist(int'(bus.o_phase), 32'h600) > 2) begin
         n_fail++; $display("FAIL midrst_phase: got 0x%03h, want 0x600", bus.o_phase);
      end
   endtask

   task automatic test_loopback();
      real    a;
      longint x, y;
      int     k;
      for (int c = 0; c < 4096 + LAT; c++) begin
         if (c < 4096) begin
            a = 2.0 * PI * real'(c) / 4096.0;
            x = longint'($floor(1073741823.0 * $cos(a) + 0.5));
            y = longint'($floor(1073741823.0 * $sin(a) + 0.5));
            drive(1, 1, x, y);
         end else begin
            drive(1, 0, 0, 0);
         end
         tick();
         if (c >= LAT - 1) begin
            k = c - LAT + 1;
            n_checks++;
            if (bus.o_valid !== (k < 4096)) begin
               n_fail++; $display("FAIL loop_valid[%0d]: got %b, want %b", k, bus.o_valid, k < 4096);
            end
            if (k < 4096) begin
               n_checks++;
               if (phase_dist(int'(bus.o_phase), k) > 2) begin
                  n_fail++; $display("FAIL loop_phase[%0d]: got 0x%03h, want 0x%03h +/-2", k, bus.o_phase, k);
               end
            end
         end
      end
   endtask

   initial begin
      drive(1, 0, 0, 0);
      test_reset();
      test_single_latency();
      test_axis_back_to_back();
      test_extremes();
      test_stall();
      test_random();
      test_reset_mid_stream();
      test_loopback();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout at %0t, want completion", $time);
      $fatal(1, "simulation time limit reached");
   end
endmodule
